uart_cmd_ctrl: RTL and testbench
================================

// Module: uart_cmd_ctrl
// PURPOSE
//  Command sequencer behind the UART receiver of the FPGA debugger.
//  - Consumes received bytes (rx_data/rx_done) and parses fixed debugger frames.
//  - Executes register reads/writes on the debug register bus over a req/ack handshake.
//  - Hands one response byte per frame to the transmit side.
//  - Reports framing, checksum, timeout and overrun errors as 1-cycle pulses.
// PARAMETERS
//  SYNC_BYTE       8'hA5  frame start marker
//  BYTE_TIMEOUT    50000  max clk cycles between frame bytes; 0 disables the check
//  ACK_TIMEOUT     1024   max clk cycles waiting for bus_ack
//  ACK_BYTE        8'h06  response to a successful write
//  NAK_BYTE        8'h15  response to a checksum or bus-timeout failure
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  rx_data     in   8  byte from UART RX; valid only when rx_done=1
//  rx_done     in   1  1-cycle strobe: new byte
//  bus_req     out  1  bus request; held until bus_ack
//  bus_we      out  1  1=write, 0=read; stable while bus_req=1
//  bus_addr    out  8  register address; stable while bus_req=1
//  bus_wdata   out  8  write data; stable while bus_req=1
//  bus_ack     in   1  1-cycle completion strobe from the register bank
//  bus_rdata   in   8  read data; valid in the cycle bus_ack=1
//  rsp_valid   out  1  response byte available
//  rsp_data    out  8  response byte; stable while rsp_valid=1
//  rsp_ready   in   1  TX side accepts the byte when rsp_valid && rsp_ready
//  err_chk     out  1  pulse: bad checksum
//  err_cmd     out  1  pulse: unknown opcode
//  err_tmo     out  1  pulse: inter-byte or bus-ack timeout
//  err_ovr     out  1  pulse: rx_done received while in S_BUS or S_RSP (byte discarded)
// BEHAVIOUR
//  Reset: every output is 0; state=S_SYNC; byte timer and ack timer are 0.
//  Frames:
//   - Write: SYNC, 0x01, ADDR, DATA, CHK. CHK = 0x01^ADDR^DATA.
//   - Read:  SYNC, 0x02, ADDR, CHK.       CHK = 0x02^ADDR.
//  States:
//   S_SYNC  - on rx_done with rx_data==SYNC_BYTE go to S_CMD.
//           - Other bytes are silently dropped. No timeout in this state.
//   S_CMD   - 0x01 or 0x02: latch the opcode, go to S_ADDR.
//           - Any other opcode: err_cmd pulse, return to S_SYNC.
//   S_ADDR  - latch ADDR. Write: go to S_DATA. Read: go to S_CHK.
//   S_DATA  - latch DATA, go to S_CHK.
//   S_CHK   - match: go to S_BUS.
//           - mismatch: err_chk pulse, rsp_data=NAK_BYTE, go to S_RSP.
//   S_BUS   - bus_req=1 with bus_we/bus_addr/bus_wdata from the latched fields.
//           - On bus_ack: bus_req=0 in the next cycle, go to S_RSP.
//           - Response byte: read gives bus_rdata sampled at ack; write gives ACK_BYTE.
//           - Ack timer counts cycles with bus_req=1. On reaching ACK_TIMEOUT:
//             drop bus_req, err_tmo pulse, rsp_data=NAK_BYTE, go to S_RSP.
//   S_RSP   - rsp_valid=1 with rsp_data held.
//           - On rsp_valid && rsp_ready: rsp_valid=0 next cycle, go to S_SYNC.
//  Byte timer (S_CMD..S_CHK only):
//   - Clears on every rx_done; increments otherwise.
//   - Reaching BYTE_TIMEOUT: err_tmo pulse, go to S_SYNC, no response.
//  Timing:
//   - Earliest bus_req: the cycle after the CHK rx_done.
//   - Earliest rsp_valid: the cycle after bus_ack.
//   - Back-to-back rx_done on consecutive cycles must be accepted.
//  Simultaneous events:
//   - bus_ack in the same cycle the ack timer expires: the ack wins, no err_tmo.
//   - rx_done in the cycle the byte timer expires: the byte wins, timer clears.
//   - Bytes arriving in S_BUS/S_RSP: discarded with err_ovr; the parser does not resync.
//  Errors: each err_* is exactly 1 cycle; a single cycle never asserts two err_* pulses.
//  Reset mid-frame or mid-transaction: immediate return to S_SYNC.
//   - bus_req and rsp_valid drop asynchronously.
//   - A late bus_ack after reset is ignored.
// TESTING
//  1. Write A5 01 10 5C 4D, ack after 3 cycles
//     -> bus_we=1, addr=0x10, wdata=0x5C; rsp_data=0x06.
//  2. Read A5 02 20 22, bus_rdata=0x9B with ack
//     -> bus_we=0, addr=0x20; rsp_data=0x9B; rsp_valid held while rsp_ready=0 for 5 cycles.
//  3. A5 01 10 5C 00 (bad CHK)
//     -> err_chk pulse, no bus_req, rsp_data=0x15.
//  4. A5 07 -> err_cmd pulse.
//     Then A5 01 with BYTE_TIMEOUT=100 and no further bytes
//     -> err_tmo at cycle 100, state S_SYNC, no rsp_valid.
//  5. Read with bus_ack withheld -> err_tmo after 1024 req cycles, rsp_data=0x15.
//     Bytes sent meanwhile -> err_ovr per byte.
//  6. Leading garbage 00 FF then a valid read -> garbage ignored, read completes.
//     Separately, assert rst_n=0 during S_BUS -> all outputs 0, next frame parses normally.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Function : debugger frame parser and register-bus sequencer behind UART RX
// Revision : 1.0  initial release
// ============================================================================
module uart_cmd_ctrl #(
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned BYTE_TIMEOUT = 50000,
   parameter int unsigned ACK_TIMEOUT  = 1024,
   parameter logic [7:0]  ACK_BYTE     = 8'h06,
   parameter logic [7:0]  NAK_BYTE     = 8'h15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data_i,
   input  logic       rx_done_i,
   output logic       bus_req_o,
   output logic       bus_we_o,
   output logic [7:0] bus_addr_o,
   output logic [7:0] bus_wdata_o,
   input  logic       bus_ack_i,
   input  logic [7:0] bus_rdata_i,
   output logic       rsp_valid_o,
   output logic [7:0] rsp_data_o,
   input  logic       rsp_ready_i,
   output logic       err_chk_o,
   output logic       err_cmd_o,
   output logic       err_tmo_o,
   output logic       err_ovr_o
);

   localparam logic [2:0] S_SYNC = 3'd0;
   localparam logic [2:0] S_CMD  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;
   localparam logic [2:0] S_BUS  = 3'd5;
   localparam logic [2:0] S_RSP  = 3'd6;

   localparam logic [7:0] OP_WR = 8'h01;
   localparam logic [7:0] OP_RD = 8'h02;

   localparam int BT_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT + 1) : 1;
   localparam int AT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
   localparam logic [AT_W-1:0] AT_LAST = AT_W'(ACK_TIMEOUT - 1);

   logic [2:0]      state_q, state_d;
   logic            we_q, we_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [BT_W-1:0] bt_q, bt_d;
   logic [AT_W-1:0] at_q, at_d;
   logic            bus_req_q, bus_req_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [7:0]      rsp_data_q, rsp_data_d;
   logic            err_chk_q, err_chk_d;
   logic            err_cmd_q, err_cmd_d;
   logic            err_tmo_q, err_tmo_d;
   logic            err_ovr_q, err_ovr_d;

   logic            in_frame;
   logic [7:0]      chk_exp;

   assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                     (state_q == S_DATA) || (state_q == S_CHK);

   // Read frames carry no data byte, so the data term drops out of the XOR.
   assign chk_exp = we_q ? (OP_WR ^ addr_q ^ wdata_q) : (OP_RD ^ addr_q);

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      bt_d        = bt_q;
      at_d        = at_q;
      bus_req_d   = bus_req_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      err_chk_d   = 1'b0;
      err_cmd_d   = 1'b0;
      err_tmo_d   = 1'b0;
      err_ovr_d   = 1'b0;

      case (state_q)
         S_SYNC: begin
            bt_d = '0;
            if (rx_done_i && (rx_data_i == SYNC_BYTE)) begin
               state_d = S_CMD;
            end
         end
         S_CMD: begin
            if (rx_done_i) begin
               if ((rx_data_i == OP_WR) || (rx_data_i == OP_RD)) begin
                  we_d    = (rx_data_i == OP_WR);
                  state_d = S_ADDR;
               end else begin
                  err_cmd_d = 1'b1;
                  state_d   = S_SYNC;
               end
            end
         end
         S_ADDR: begin
            if (rx_done_i) begin
               addr_d  = rx_data_i;
               state_d = we_q ? S_DATA : S_CHK;
            end
         end
         S_DATA: begin
            if (rx_done_i) begin
               wdata_d = rx_data_i;
               state_d = S_CHK;
            end
         end
         S_CHK: begin
            if (rx_done_i) begin
               if (rx_data_i == chk_exp) begin
                  bus_req_d = 1'b1;
                  at_d      = '0;
                  state_d   = S_BUS;
               end else begin
                  err_chk_d   = 1'b1;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = NAK_BYTE;
                  state_d     = S_RSP;
               end
            end
         end
         S_BUS: begin
            // An ack arriving on the expiry cycle takes priority over the timeout.
            if (bus_ack_i) begin
               bus_req_d   = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_data_d  = we_q ? ACK_BYTE : bus_rdata_i;
               state_d     = S_RSP;
            end else if (at_q == AT_LAST) begin
               bus_req_d   = 1'b0;
               err_tmo_d   = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_data_d  = NAK_BYTE;
               state_d     = S_RSP;
            end else begin
               at_d = at_q + AT_W'(1);
            end
            if (rx_done_i && !err_tmo_d) begin
               err_ovr_d = 1'b1;
            end
         end
         S_RSP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = S_SYNC;
            end
            if (rx_done_i) begin
               err_ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = S_SYNC;
         end
      endcase

      // A byte landing on the expiry cycle wins and restarts the gap timer.
      if (in_frame) begin
         if (rx_done_i) begin
            bt_d = '0;
         end else if ((BYTE_TIMEOUT != 0) && (bt_q == BT_LAST)) begin
            bt_d      = '0;
            err_tmo_d = 1'b1;
            state_d   = S_SYNC;
         end else begin
            bt_d = bt_q + BT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_SYNC;
         we_q        <= 1'b0;
         addr_q      <= 8'h00;
         wdata_q     <= 8'h00;
         bt_q        <= '0;
         at_q        <= '0;
         bus_req_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'h00;
         err_chk_q   <= 1'b0;
         err_cmd_q   <= 1'b0;
         err_tmo_q   <= 1'b0;
         err_ovr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         bt_q        <= bt_d;
         at_q        <= at_d;
         bus_req_q   <= bus_req_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         err_chk_q   <= err_chk_d;
         err_cmd_q   <= err_cmd_d;
         err_tmo_q   <= err_tmo_d;
         err_ovr_q   <= err_ovr_d;
      end
   end

   assign bus_req_o   = bus_req_q;
   assign bus_we_o    = we_q;
   assign bus_addr_o  = addr_q;
   assign bus_wdata_o = wdata_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_data_o  = rsp_data_q;
   assign err_chk_o   = err_chk_q;
   assign err_cmd_o   = err_cmd_q;
   assign err_tmo_o   = err_tmo_q;
   assign err_ovr_o   = err_ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Function : self-checking bench for uart_cmd_ctrl with a frame-level model
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_done = 1'b0;
   logic       bus_ack = 1'b0;
   logic [7:0] bus_rdata = 8'h00;
   logic       rsp_ready = 1'b0;
   logic       bus_req_o, bus_we_o, rsp_valid_o;
   logic [7:0] bus_addr_o, bus_wdata_o, rsp_data_o;
   logic       err_chk_o, err_cmd_o, err_tmo_o, err_ovr_o;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(.BYTE_TIMEOUT(100)) dut (
      .clk(clk), .rst_n(rst_n),
      .rx_data_i(rx_data), .rx_done_i(rx_done),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
      .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
      .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_ready_i(rsp_ready),
      .err_chk_o(err_chk_o), .err_cmd_o(err_cmd_o),
      .err_tmo_o(err_tmo_o), .err_ovr_o(err_ovr_o)
   );

   int n_cmp = 0;
   int n_fail = 0;

   // bus responder configuration
   bit         ack_en = 1'b1;
   int         ack_dly = 0;
   logic [7:0] rd_cfg = 8'h00;

   // monitor state
   int cyc = 0;
   int n_chk = 0, n_cmd = 0, n_tmo = 0, n_ovr = 0, n_multi = 0;
   int n_txn = 0, n_unstable = 0, req_len = 0, n_rsp_rise = 0;
   int ack_cyc = -1, rise_cyc = -1;
   bit cap_we;
   logic [7:0] cap_addr, cap_wdata;
   int s_chk, s_cmd, s_tmo, s_ovr, s_txn, s_rise;

   typedef struct {
      bit         has_txn;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      bit         has_rsp;
      logic [7:0] rsp;
      int         e_chk;
      int         e_cmd;
   } exp_t;

   // Scan a byte stream the way the frame format defines it.
   function automatic exp_t model(input logic [7:0] q[$], input logic [7:0] rd);
      exp_t e;
      int i;
      logic [7:0] op, ad, dt, ck;
      e = '{default: 0};
      i = 0;
      while (i < q.size() && q[i] != 8'hA5) i++;
      i++;
      if (i >= q.size()) return e;
      op = q[i]; i++;
      if (op != 8'h01 && op != 8'h02) begin
         e.e_cmd = 1;
         return e;
      end
      ad = q[i]; i++;
      dt = 8'h00;
      if (op == 8'h01) begin dt = q[i]; i++; end
      ck = q[i];
      e.has_rsp = 1'b1;
      if (ck == (op ^ ad ^ dt)) begin
         e.has_txn = 1'b1;
         e.we      = (op == 8'h01);
         e.addr    = ad;
         e.wdata   = dt;
         e.rsp     = (op == 8'h01) ? 8'h06 : rd;
      end else begin
         e.e_chk = 1;
         e.rsp   = 8'h15;
      end
      return e;
   endfunction

   initial begin : responder
      forever begin
         @(posedge clk); #1;
         if (bus_req_o && ack_en) begin
            repeat (ack_dly) begin @(posedge clk); #1; end
            bus_ack = 1'b1;
            bus_rdata = rd_cfg;
            @(posedge clk); #1;
            bus_ack = 1'b0;
            bus_rdata = 8'h00;
         end
      end
   end

   initial begin : monitor
      bit req_prev, rspv_prev;
      req_prev = 1'b0;
      rspv_prev = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            req_prev = 1'b0;
            rspv_prev = 1'b0;
         end else begin
            n_chk += int'(err_chk_o);
            n_cmd += int'(err_cmd_o);
            n_tmo += int'(err_tmo_o);
            n_ovr += int'(err_ovr_o);
            if ((int'(err_chk_o) + int'(err_cmd_o) + int'(err_tmo_o) + int'(err_ovr_o)) > 1)
               n_multi++;
            if (bus_req_o && !req_prev) begin
               n_txn++;
               req_len = 1;
               cap_we = bus_we_o;
               cap_addr = bus_addr_o;
               cap_wdata = bus_wdata_o;
            end else if (bus_req_o) begin
               req_len++;
               if (bus_we_o !== cap_we || bus_addr_o !== cap_addr ||
                   (cap_we && bus_wdata_o !== cap_wdata))
                  n_unstable++;
            end
            if (bus_ack) ack_cyc = cyc;
            if (rsp_valid_o && !rspv_prev) begin
               n_rsp_rise++;
               rise_cyc = cyc;
            end
            req_prev = bus_req_o;
            rspv_prev = rsp_valid_o;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data = b;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
      rx_data = 8'h00;
   endtask

   task automatic send_q(input logic [7:0] q[$]);
      foreach (q[i]) send_byte(q[i]);
   endtask

   task automatic snap();
      s_chk = n_chk; s_cmd = n_cmd; s_tmo = n_tmo; s_ovr = n_ovr;
      s_txn = n_txn; s_rise = n_rsp_rise;
   endtask

   // Wait (bounded) for a response, hold it off for 'hold' cycles, then accept it.
   task automatic wait_rsp(input int hold, output bit got, output logic [7:0] data,
                           output bit stable, output bit dropped);
      int k;
      got = 1'b0; stable = 1'b1; dropped = 1'b0; data = 8'h00;
      for (k = 0; k < 1500 && !rsp_valid_o; k++) tick();
      if (!rsp_valid_o) return;
      got = 1'b1;
      data = rsp_data_o;
      repeat (hold) begin
         tick();
         if (!rsp_valid_o || rsp_data_o !== data) stable = 1'b0;
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      dropped = !rsp_valid_o;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle(3);
      n_cmp++;
      if ({bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, rsp_valid_o, rsp_data_o,
           err_chk_o, err_cmd_o, err_tmo_o, err_ovr_o} !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got=%h exp=0", {bus_req_o, bus_we_o, bus_addr_o,
                  bus_wdata_o, rsp_valid_o, rsp_data_o, err_chk_o, err_cmd_o, err_tmo_o, err_ovr_o});
      end
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_write();
      bit got, st, dr; logic [7:0] d;
      snap();
      ack_dly = 3;
      send_q('{8'hA5, 8'h01, 8'h10, 8'h5C, 8'h4D});
      n_cmp++;
      if (bus_req_o !== 1'b1) begin n_fail++; $display("FAIL wr_req_latency got=%b exp=1", bus_req_o); end
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (n_txn - s_txn !== 1) begin n_fail++; $display("FAIL wr_txn_count got=%0d exp=1", n_txn - s_txn); end
      n_cmp++; if (cap_we !== 1'b1) begin n_fail++; $display("FAIL wr_we got=%b exp=1", cap_we); end
      n_cmp++; if (cap_addr !== 8'h10) begin n_fail++; $display("FAIL wr_addr got=%h exp=10", cap_addr); end
      n_cmp++; if (cap_wdata !== 8'h5C) begin n_fail++; $display("FAIL wr_wdata got=%h exp=5c", cap_wdata); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h06) begin n_fail++; $display("FAIL wr_rsp got=%b/%h exp=1/06", got, d); end
      n_cmp++; if (rise_cyc !== ack_cyc + 1) begin n_fail++; $display("FAIL wr_rsp_latency got=%0d exp=%0d", rise_cyc, ack_cyc + 1); end
      n_cmp++; if (dr !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_drop got=%b exp=1", dr); end
   endtask

   task automatic test_read();
      bit got, st, dr; logic [7:0] d;
      snap();
      ack_dly = 1;
      rd_cfg = 8'h9B;
      send_q('{8'hA5, 8'h02, 8'h20, 8'h22});
      wait_rsp(5, got, d, st, dr);
      n_cmp++; if (n_txn - s_txn !== 1 || cap_we !== 1'b0 || cap_addr !== 8'h20) begin
         n_fail++; $display("FAIL rd_txn got=%0d/%b/%h exp=1/0/20", n_txn - s_txn, cap_we, cap_addr); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h9B) begin n_fail++; $display("FAIL rd_rsp got=%b/%h exp=1/9b", got, d); end
      n_cmp++; if (st !== 1'b1 || dr !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_hold got=%b/%b exp=1/1", st, dr); end
   endtask

   task automatic test_bad_chk();
      bit got, st, dr; logic [7:0] d;
      snap();
      send_q('{8'hA5, 8'h01, 8'h10, 8'h5C, 8'h00});
      wait_rsp(1, got, d, st, dr);
      n_cmp++; if (n_chk - s_chk !== 1) begin n_fail++; $display("FAIL chk_pulse got=%0d exp=1", n_chk - s_chk); end
      n_cmp++; if (n_txn - s_txn !== 0) begin n_fail++; $display("FAIL chk_no_bus got=%0d exp=0", n_txn - s_txn); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h15) begin n_fail++; $display("FAIL chk_rsp got=%b/%h exp=1/15", got, d); end
   endtask

   task automatic test_cmd_timeout();
      bit got, st, dr; logic [7:0] d;
      int n;
      snap();
      send_q('{8'hA5, 8'h07});
      idle(4);
      n_cmp++; if (n_cmd - s_cmd !== 1) begin n_fail++; $display("FAIL cmd_pulse got=%0d exp=1", n_cmd - s_cmd); end
      snap();
      send_q('{8'hA5, 8'h01});
      n = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (err_tmo_o) begin n = k; break; end
      end
      n_cmp++; if (n !== 100) begin n_fail++; $display("FAIL byte_tmo_cycle got=%0d exp=100", n); end
      idle(5);
      n_cmp++; if (n_tmo - s_tmo !== 1 || n_rsp_rise - s_rise !== 0) begin
         n_fail++; $display("FAIL byte_tmo_norsp got=%0d/%0d exp=1/0", n_tmo - s_tmo, n_rsp_rise - s_rise); end
      // bytes landing exactly on the expiry cycle keep the frame alive
      snap();
      ack_dly = 0;
      send_byte(8'hA5); send_byte(8'h01); idle(99);
      send_byte(8'h30); idle(99);
      send_byte(8'h44); idle(99);
      send_byte(8'h75);
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (n_tmo - s_tmo !== 0) begin n_fail++; $display("FAIL byte_boundary_tmo got=%0d exp=0", n_tmo - s_tmo); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h06 || cap_addr !== 8'h30 || cap_wdata !== 8'h44) begin
         n_fail++; $display("FAIL byte_boundary_wr got=%b/%h/%h/%h exp=1/06/30/44", got, d, cap_addr, cap_wdata); end
   endtask

   task automatic test_ack_timeout();
      bit got, st, dr; logic [7:0] d;
      snap();
      ack_en = 1'b0;
      send_q('{8'hA5, 8'h02, 8'h20, 8'h22});
      idle(2); send_byte(8'hA5); idle(3); send_byte(8'h02); send_byte(8'h7E);
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (req_len !== 1024) begin n_fail++; $display("FAIL ack_tmo_len got=%0d exp=1024", req_len); end
      n_cmp++; if (n_tmo - s_tmo !== 1) begin n_fail++; $display("FAIL ack_tmo_pulse got=%0d exp=1", n_tmo - s_tmo); end
      n_cmp++; if (n_ovr - s_ovr !== 3) begin n_fail++; $display("FAIL ovr_count got=%0d exp=3", n_ovr - s_ovr); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h15) begin n_fail++; $display("FAIL ack_tmo_rsp got=%b/%h exp=1/15", got, d); end
      ack_en = 1'b1;
      // ack on the very cycle the timer expires wins
      snap();
      ack_dly = 1023;
      send_q('{8'hA5, 8'h01, 8'h33, 8'h0F, 8'h3D});
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (req_len !== 1024 || n_tmo - s_tmo !== 0) begin
         n_fail++; $display("FAIL ack_boundary got=%0d/%0d exp=1024/0", req_len, n_tmo - s_tmo); end
      n_cmp++; if (got !== 1'b1 || d !== 8'h06) begin n_fail++; $display("FAIL ack_boundary_rsp got=%b/%h exp=1/06", got, d); end
   endtask

   task automatic test_garbage_reset();
      bit got, st, dr; logic [7:0] d;
      bit req_before;
      snap();
      ack_dly = 2;
      rd_cfg = 8'hC3;
      send_q('{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h41, 8'h43});
      wait_rsp(2, got, d, st, dr);
      n_cmp++; if (got !== 1'b1 || d !== 8'hC3 || cap_addr !== 8'h41 || n_txn - s_txn !== 1) begin
         n_fail++; $display("FAIL garbage_rd got=%b/%h/%h exp=1/c3/41", got, d, cap_addr); end
      ack_dly = 10;
      send_q('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27});
      idle(2);
      req_before = bus_req_o;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (req_before !== 1'b1 || {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, rsp_valid_o, rsp_data_o} !== 27'd0) begin
         n_fail++; $display("FAIL async_reset got=%b/%h exp=1/0", req_before,
                            {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, rsp_valid_o, rsp_data_o}); end
      idle(2);
      rst_n = 1'b1;
      snap();
      idle(15);
      n_cmp++; if (n_rsp_rise - s_rise !== 0 || n_txn - s_txn !== 0) begin
         n_fail++; $display("FAIL late_ack got=%0d/%0d exp=0/0", n_rsp_rise - s_rise, n_txn - s_txn); end
      ack_dly = 0;
      send_q('{8'hA5, 8'h01, 8'h12, 8'h34, 8'h27});
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (got !== 1'b1 || d !== 8'h06 || cap_wdata !== 8'h34) begin
         n_fail++; $display("FAIL post_reset_wr got=%b/%h/%h exp=1/06/34", got, d, cap_wdata); end
   endtask

   task automatic test_back_to_back();
      bit got, st, dr; logic [7:0] d;
      snap();
      ack_dly = 0;
      rd_cfg = 8'h5A;
      send_q('{8'hA5, 8'h02, 8'h01, 8'h03});
      wait_rsp(0, got, d, st, dr);
      rd_cfg = 8'hA6;
      send_q('{8'hA5, 8'h02, 8'h02, 8'h00});
      wait_rsp(0, got, d, st, dr);
      n_cmp++; if (got !== 1'b1 || d !== 8'hA6 || cap_addr !== 8'h02 || n_txn - s_txn !== 2) begin
         n_fail++; $display("FAIL b2b got=%b/%h/%h/%0d exp=1/a6/02/2", got, d, cap_addr, n_txn - s_txn); end
   endtask

   task automatic test_random();
      bit got, st, dr; logic [7:0] d;
      exp_t e;
      logic [7:0] q[$];
      logic [7:0] op, ad, dt, ck, g;
      int kind;
      for (int it = 0; it < 24; it++) begin
         q.delete();
         repeat ($urandom_range(0, 2)) begin
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h5A;
            q.push_back(g);
         end
         kind = $urandom_range(0, 3);
         ad = 8'($urandom); dt = 8'($urandom);
         op = (kind == 1) ? 8'h02 : 8'h01;
         if (kind == 3) begin
            op = 8'($urandom);
            if (op == 8'h01 || op == 8'h02) op = 8'h80;
         end
         q.push_back(8'hA5); q.push_back(op);
         if (kind != 3) begin
            q.push_back(ad);
            if (op == 8'h01) q.push_back(dt);
            ck = op ^ ad ^ ((op == 8'h01) ? dt : 8'h00);
            if (kind == 2) ck = ck ^ 8'(1 << $urandom_range(0, 7));
            q.push_back(ck);
         end
         ack_dly = $urandom_range(0, 5);
         rd_cfg = 8'($urandom);
         e = model(q, rd_cfg);
         snap();
         send_q(q);
         if (e.has_rsp) wait_rsp($urandom_range(0, 3), got, d, st, dr);
         else begin idle(5); got = (n_rsp_rise != s_rise); d = 8'h00; end
         n_cmp++; if (n_txn - s_txn !== int'(e.has_txn)) begin
            n_fail++; $display("FAIL rnd%0d_txn got=%0d exp=%0d", it, n_txn - s_txn, e.has_txn); end
         if (e.has_txn) begin
            n_cmp++; if (cap_we !== e.we || cap_addr !== e.addr || (e.we && cap_wdata !== e.wdata)) begin
               n_fail++; $display("FAIL rnd%0d_bus got=%b/%h/%h exp=%b/%h/%h", it, cap_we, cap_addr, cap_wdata, e.we, e.addr, e.wdata); end
         end
         n_cmp++; if (got !== e.has_rsp || (e.has_rsp && d !== e.rsp)) begin
            n_fail++; $display("FAIL rnd%0d_rsp got=%b/%h exp=%b/%h", it, got, d, e.has_rsp, e.rsp); end
         n_cmp++; if (n_chk - s_chk !== e.e_chk || n_cmd - s_cmd !== e.e_cmd || n_tmo - s_tmo !== 0) begin
            n_fail++; $display("FAIL rnd%0d_err got=%0d/%0d/%0d exp=%0d/%0d/0", it, n_chk - s_chk, n_cmd - s_cmd, n_tmo - s_tmo, e.e_chk, e.e_cmd); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_bad_chk();
      test_cmd_timeout();
      test_ack_timeout();
      test_garbage_reset();
      test_back_to_back();
      test_random();
      idle(3);
      n_cmp++; if (n_multi !== 0 || n_unstable !== 0) begin
         n_fail++; $display("FAIL global_err_bus got=%0d/%0d exp=0/0", n_multi, n_unstable); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
